// File: rtl/sccb_cfg_ctrl.sv
// rtl/sccb_cfg_ctrl.sv - OV7670 power-up register walker over SCCB 3-phase writes
module sccb_cfg_ctrl #(
   parameter int         CLK_DIV    = 125,
   parameter int         NUM_REGS   = 32,
   parameter logic [7:0] DEV_ADDR   = 8'h42,
   parameter int         RESET_WAIT = 25000,
   // One extra bit so the index can reach NUM_REGS and stop there without wrapping
   localparam int        IDX_W      = $clog2(NUM_REGS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   output logic [IDX_W-1:0] tbl_idx,
   input  logic [15:0]      tbl_data,
   output logic             sioc_o,
   output logic             siod_o,
   output logic             siod_oe,
   input  logic             siod_i,
   output logic             busy,
   output logic             done,
   output logic             nack
);

   localparam int CNT_W  = $clog2(CLK_DIV + 1);
   localparam int WAIT_W = $clog2(RESET_WAIT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_ST1, S_ST2, S_BIT_L, S_BIT_H,
      S_SP1, S_SP2, S_SP3, S_GAP, S_WAIT, S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [WAIT_W-1:0] wcnt;
   logic [23:0]       shreg;
   logic [15:0]       entry;
   logic [3:0]        bit_cnt;
   logic [1:0]        byte_cnt;

   logic tick, ack_slot, last_slot, load_last, wait_req, start_ok;

   assign tick      = (cnt == CNT_W'(CLK_DIV - 1));
   assign ack_slot  = (bit_cnt == 4'd8);
   assign last_slot = ack_slot && (byte_cnt == 2'd2);
   assign load_last = (cnt == CNT_W'(1));
   assign wait_req  = (entry[15:8] == 8'h12) && entry[7];
   assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

   // Next-state decode and bus pin levels for each phase
   always_comb begin
      state_nx = state;
      sioc_o   = 1'b1;
      siod_o   = 1'b1;
      siod_oe  = 1'b1;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = S_LOAD;
         end
         S_LOAD: begin
            if (load_last) begin
               if (tbl_data == 16'hFFFF || tbl_idx == IDX_W'(NUM_REGS)) state_nx = S_DONE;
               else                                                      state_nx = S_ST1;
            end
         end
         S_ST1: begin
            siod_o = 1'b0;
            if (tick) state_nx = S_ST2;
         end
         S_ST2: begin
            sioc_o = 1'b0;
            siod_o = 1'b0;
            if (tick) state_nx = S_BIT_L;
         end
         S_BIT_L, S_BIT_H: begin
            sioc_o  = (state == S_BIT_H);
            siod_o  = ack_slot ? 1'b1 : shreg[23];
            siod_oe = !ack_slot;
            if (tick) begin
               if (state == S_BIT_L) state_nx = S_BIT_H;
               else                  state_nx = last_slot ? S_SP1 : S_BIT_L;
            end
         end
         S_SP1: begin
            sioc_o = 1'b0;
            siod_o = 1'b0;
            if (tick) state_nx = S_SP2;
         end
         S_SP2: begin
            siod_o = 1'b0;
            if (tick) state_nx = S_SP3;
         end
         S_SP3: begin
            if (tick) state_nx = S_GAP;
         end
         S_GAP: begin
            if (tick) state_nx = wait_req ? S_WAIT : S_LOAD;
         end
         S_WAIT: begin
            if (wcnt == WAIT_W'(RESET_WAIT - 1)) state_nx = S_LOAD;
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) state_nx = S_LOAD;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State, counters, shift data and status; everything holds while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         wcnt     <= '0;
         tbl_idx  <= '0;
         shreg    <= '0;
         entry    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         nack     <= 1'b0;
      end else if (ena) begin
         state <= state_nx;
         if (!busy || state_nx != state || tick) cnt <= '0;
         else                                    cnt <= cnt + CNT_W'(1);
         wcnt <= (state == S_WAIT) ? wcnt + WAIT_W'(1) : '0;
         if (start_ok) begin
            tbl_idx <= '0;
            nack    <= 1'b0;
         end
         if (state == S_LOAD && load_last) begin
            entry    <= tbl_data;
            shreg    <= {DEV_ADDR, tbl_data};
            bit_cnt  <= '0;
            byte_cnt <= '0;
         end
         if (state == S_BIT_H && tick) begin
            if (ack_slot) begin
               bit_cnt  <= '0;
               byte_cnt <= byte_cnt + 2'd1;
               if (siod_i) nack <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               shreg   <= {shreg[22:0], 1'b0};
            end
         end
         if ((state == S_GAP || state == S_WAIT) && state_nx == S_LOAD)
            tbl_idx <= tbl_idx + IDX_W'(1);
      end
   end

endmodule
